// File: rtl/add_share_arbiter.sv
// add_share_arbiter: round-robin sharing of one WIDTH-bit adder among N_REQ
// requesters, with a one-entry registered output stage (sum, carry, id).
// Optional build macro ADD_SHARE_SATURATE_EN: when defined, an overflowing
// sum is clamped to all ones instead of wrapping (carry still reports 1).
//
// Output stage states:
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_EMPTY | no result held, rsp_valid=0, a grant may load a result
//   ST_FULL  | result held, rsp_valid=1, refill only when rsp_ready=1
module add_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_carry,
  output logic [IDW-1:0]         rsp_id
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDW-1:0]   id_q, id_d;

  logic             can_accept;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic             accept;
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_res;

  // Unpack the flat operand buses into per-requester words.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  // N_REQ is a power of two, so IDW-bit addition wraps modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = rr_ptr_q + IDW'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // One-hot ready to the winner whenever the output stage can take a result.
  // Held low during reset so nothing is acknowledged that will be dropped.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) | rsp_ready;
    accept     = gnt_found & can_accept & rst_n;
    req_ready  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept && (gnt_idx == IDW'(i))) req_ready[i] = 1'b1;
    end
  end

  // Shared adder on the granted operand pair, with optional clamp on overflow.
  always_comb begin
    a_sel    = a_arr[gnt_idx];
    b_sel    = b_arr[gnt_idx];
    sum_full = {1'b0, a_sel} + {1'b0, b_sel};
`ifdef ADD_SHARE_SATURATE_EN
    sum_res  = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    sum_res  = sum_full[WIDTH-1:0];
`endif
  end

  // Next-state for the output stage and round-robin pointer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    id_d     = id_q;
    if (accept) begin
      state_d  = ST_FULL;
      sum_d    = sum_res;
      carry_d  = sum_full[WIDTH];
      id_d     = gnt_idx;
      rr_ptr_d = gnt_idx + IDW'(1);
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d  = ST_EMPTY;
    end
  end

  // State and result registers; reset discards any held result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      id_q     <= id_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Round-robin arbiter and sequencer that shares a single WIDTH-bit adder among N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, performs the addition, and holds the registered sum, carry and requester ID in a one-entry output stage until the consumer accepts it. It sits between the project's input-decoding logic and the output pins of the tile, replacing direct wiring of the adder.

## Interface
Parameters:
- N_REQ, default 4: number of requesters; must be a power of two, 2..8.
- WIDTH, default 8: operand and sum width in bits.
- IDW, default $clog2(N_REQ): width of the requester ID.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, N_REQ: bit i high means requester i has an operand pair.
- req_ready, output, N_REQ: bit i high means requester i's pair is accepted this cycle. At most one bit is high.
- req_a, input, N_REQ*WIDTH: operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b, input, N_REQ*WIDTH: operand B; same packing as req_a.
- rsp_valid, output, 1: the output stage holds a result.
- rsp_ready, input, 1: the consumer accepts the result.
- rsp_sum, output, WIDTH: registered sum.
- rsp_carry, output, 1: carry-out (overflow) of the addition.
- rsp_id, output, IDW: index of the requester that produced this result.

## Operation
- The output stage has two states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- The stage can accept a new result when `can_accept = ~rsp_valid | rsp_ready`.
- Grant is combinational. The winner is the first requester with req_valid set, searching from rr_ptr upward and wrapping modulo N_REQ.
- Ready rule: req_ready[g] = can_accept for the winner g; all other req_ready bits are 0.
- req_ready is independent of rsp_valid/rsp_ready timing beyond can_accept. No combinational path exists from req_valid to req_valid.
- On accept (req_valid[g] & req_ready[g]):
  - {rsp_carry, rsp_sum} <= a_g + b_g, computed at WIDTH+1 bits.
  - rsp_id <= g.
  - rsp_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
- Drain without refill (rsp_valid & rsp_ready with no accept): rsp_valid <= 0. The sum, carry and ID registers hold their last value.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and rsp_valid stays 1. Throughput is one result per cycle.
- No request pending: rr_ptr holds its value.
- Backpressure (rsp_valid=1, rsp_ready=0): all req_ready bits are 0, and rsp_* outputs stay stable until accepted.
- Requesters must hold req_a/req_b stable while req_valid is high and ready is low. The block does not check this.

## Timing
- Reset values:
  - rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, rr_ptr=0.
  - req_ready=0 while rst_n is low.
- Reset mid-operation: a held result is discarded immediately (asynchronous). The first grant after reset starts from requester 0.
- Latency: a request accepted at edge k produces rsp_valid=1 with valid data after edge k.
- Fairness: a continuously-valid requester waits at most N_REQ-1 grants.
- Wrap-around: rr_ptr after granting requester N_REQ-1 is 0.

## Configuration
- ADD_SHARE_SATURATE_EN:
  - Defined: when the WIDTH+1-bit sum overflows, rsp_sum is forced to all ones. rsp_carry still reports 1.
  - Undefined: rsp_sum is the modulo-2^WIDTH wrapped sum.
- All handshake and timing behaviour is identical in both builds.

## Test plan
- Reset release, req_valid[0]=1 with a=8'h12, b=8'h34, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_sum=8'h46, rsp_carry=0, rsp_id=0.
- All four requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,… with one result per cycle.
- Requester 2 with a=8'hF0, b=8'h20 -> rsp_carry=1. rsp_sum=8'h10 without ADD_SHARE_SATURATE_EN, 8'hFF with it.
- Result held with rsp_ready=0 for 5 cycles while requests pend -> req_ready=0 throughout and rsp_* stable. On rsp_ready=1, the next result loads on the same edge.
- Only requester 3 valid while rr_ptr=1 -> requester 3 granted, then rr_ptr=0.
- rst_n pulsed low while rsp_valid=1 -> rsp_valid drops without waiting for a clock edge, and the next grant starts from requester 0.
